// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: register map, STATUS/CTRL bit indices and FSM state types
// shared by the uart bus controller and its FIFOs.
package uart_ctrl_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_TX_OVF   = 5;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  typedef enum logic [1:0] {T_IDLE, T_WRITE, T_WAIT} tx_state_t;
  typedef enum logic       {R_IDLE, R_ACK}           rx_state_t;

endpackage

// File: rtl/uart_ctrl_fifo.sv
// uart_ctrl_fifo: synchronous FIFO with show-ahead read data (dout is the
// head entry whenever not empty). A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is dropped.
module uart_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // storage array, no reset needed: entries are only read once written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: CPU byte-bus controller for one uart. TX/RX FIFOs, level
// handshake sequencing (write/tx_ready, read/rx_new), sticky overflow flags.
// Optional feature macro: UART_CTRL_IRQ_EN enables the CTRL register and irq;
// without it CTRL reads 0, ignores writes and irq is tied low.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  input  logic       bus_we,
  input  logic       bus_re,
  output logic [7:0] bus_rdata,
  output logic [7:0] u_tx_data,
  output logic       u_write,
  input  logic       u_tx_ready,
  input  logic [7:0] u_rx_data,
  input  logic       u_rx_new,
  output logic       u_read,
  output logic       irq
);
  tx_state_t  tx_st;
  rx_state_t  rx_st;
  logic [7:0] tx_dout, rx_dout, status;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       tx_ovf, rx_ovf, tx_ovf_set, rx_ovf_set, st_wr;

  assign tx_push = bus_we && (bus_addr == REG_DATA);
  assign tx_pop  = (tx_st == T_IDLE) && !tx_empty && u_tx_ready;
  assign rx_push = (rx_st == R_IDLE) && u_rx_new;
  assign rx_pop  = bus_re && (bus_addr == REG_DATA) && !rx_empty;
  // a same-cycle pop makes room, so only an unrelieved full push overflows
  assign tx_ovf_set = tx_push && tx_full && !tx_pop;
  assign rx_ovf_set = rx_push && rx_full && !rx_pop;
  assign st_wr      = bus_we && (bus_addr == REG_STATUS);
  assign status     = {2'b00, tx_ovf, rx_ovf, tx_full, tx_empty, rx_full, rx_empty};

  uart_ctrl_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .din(bus_wdata),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty));

  uart_ctrl_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .din(u_rx_data),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty));

  // TX handshake: load byte and raise write, drop it once uart goes busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st     <= T_IDLE;
      u_write   <= 1'b0;
      u_tx_data <= 8'h00;
    end else begin
      case (tx_st)
        T_IDLE:  if (tx_pop) begin
                   u_tx_data <= tx_dout;
                   u_write   <= 1'b1;
                   tx_st     <= T_WRITE;
                 end
        T_WRITE: if (!u_tx_ready) begin
                   u_write <= 1'b0;
                   tx_st   <= T_WAIT;
                 end
        T_WAIT:  if (u_tx_ready) tx_st <= T_IDLE;
        default: tx_st <= T_IDLE;
      endcase
    end
  end

  // RX handshake: capture on rx_new, ack with read until rx_new drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st  <= R_IDLE;
      u_read <= 1'b0;
    end else begin
      case (rx_st)
        R_IDLE:  if (u_rx_new) begin
                   u_read <= 1'b1;
                   rx_st  <= R_ACK;
                 end
        R_ACK:   if (!u_rx_new) begin
                   u_read <= 1'b0;
                   rx_st  <= R_IDLE;
                 end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  // sticky overflow flags, W1C via STATUS; a same-cycle set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (tx_ovf_set)                     tx_ovf <= 1'b1;
      else if (st_wr && bus_wdata[ST_TX_OVF]) tx_ovf <= 1'b0;
      if (rx_ovf_set)                     rx_ovf <= 1'b1;
      else if (st_wr && bus_wdata[ST_RX_OVF]) rx_ovf <= 1'b0;
    end
  end

`ifdef UART_CTRL_IRQ_EN
  logic [1:0] ctrl;

  // CTRL register: interrupt enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  ctrl <= 2'b00;
    else if (bus_we && (bus_addr == REG_CTRL))   ctrl <= bus_wdata[1:0];
  end

  // registered interrupt level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= (ctrl[CTRL_RX_IE] & ~rx_empty) | (ctrl[CTRL_TX_IE] & tx_empty)
                       | tx_ovf | rx_ovf;
  end

  wire [7:0] ctrl_rd = {6'b0, ctrl};
`else
  assign irq = 1'b0;
  wire [7:0] ctrl_rd = 8'h00;
`endif

  // registered bus read mux; empty DATA reads return 0 without popping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_rdata <= 8'h00;
    else if (bus_re) begin
      case (bus_addr)
        REG_DATA:   bus_rdata <= rx_empty ? 8'h00 : rx_dout;
        REG_STATUS: bus_rdata <= status;
        REG_CTRL:   bus_rdata <= ctrl_rd;
        default:    bus_rdata <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: scoreboard bench for uart_ctrl with a behavioural uart
// handshake model (tx_ready drops after a write rise, returns 3 cycles later).
module tb_uart_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] bus_addr = 2'd0;
  logic [7:0] bus_wdata = 8'h00;
  logic       bus_we = 1'b0;
  logic       bus_re = 1'b0;
  logic [7:0] bus_rdata;
  logic [7:0] u_tx_data;
  logic       u_write;
  logic       u_tx_ready = 1'b1;
  logic [7:0] u_rx_data = 8'h00;
  logic       u_rx_new = 1'b0;
  logic       u_read;
  logic       irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic       tx_hold = 1'b0;
  int         tx_cnt = 0;
  logic       prev_write = 1'b0;
  logic [7:0] rd;

  uart_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata),
    .u_tx_data(u_tx_data), .u_write(u_write), .u_tx_ready(u_tx_ready),
    .u_rx_data(u_rx_data), .u_rx_new(u_rx_new), .u_read(u_read), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // uart TX side model and scoreboard check on each write rise
  always @(negedge clk) begin
    if (u_write && !prev_write) begin
      if (tx_exp.size() == 0) chk("tx_extra", 8'h01, 8'h00);
      else begin
        chk("tx_rdy", {7'b0, u_tx_ready}, 8'h01);
        chk("tx_data", u_tx_data, tx_exp.pop_front());
      end
      tx_cnt = 3;
      u_tx_ready = 1'b0;
    end else if (tx_cnt != 0) tx_cnt--;
    if (tx_hold)           u_tx_ready = 1'b0;
    else if (tx_cnt == 0)  u_tx_ready = 1'b1;
    prev_write = u_write;
  end

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
    d = bus_rdata;
  endtask

  // present one byte from the uart and follow the read handshake
  task automatic rx_send(input logic [7:0] b);
    logic ok;
    @(negedge clk);
    u_rx_data = b; u_rx_new = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = u_read;
    end
    chk("rx_ack", {7'b0, ok}, 8'h01);
    u_rx_new = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = !u_read;
    end
    chk("rx_rel", {7'b0, ok}, 8'h01);
  endtask

  task automatic tx_drain();
    for (int i = 0; i < 500 && tx_exp.size() != 0; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk("tx_drain", 8'(tx_exp.size()), 8'h00);
  endtask

  initial begin
    // 1 reset
    repeat (3) @(negedge clk);
    chk("rst_write", {7'b0, u_write}, 8'h00);
    chk("rst_read", {7'b0, u_read}, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    rst_n = 1'b1;
    bus_read(2'd1, rd); chk("rst_status", rd, 8'h05);
    bus_read(2'd3, rd); chk("reserved", rd, 8'h00);

    // 2 three TX bytes
    for (int i = 0; i < 3; i++) begin
      tx_exp.push_back(8'(8'h41 + i));
      bus_write(2'd0, 8'(8'h41 + i));
    end
    tx_drain();

    // 3 overflow TX while uart busy, then W1C
    tx_hold = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_exp.push_back(8'(8'h60 + i));
      bus_write(2'd0, 8'(8'h60 + i));
    end
    bus_read(2'd1, rd); chk("tx_ovf_status", rd, 8'h29);
    bus_write(2'd1, 8'h20);
    bus_read(2'd1, rd); chk("tx_ovf_clr", rd, 8'h09);
    tx_hold = 1'b0;
    tx_drain();

    // 4 single RX byte
    rx_exp.push_back(8'h5A);
    rx_send(8'h5A);
    bus_read(2'd1, rd); chk("rx_status", rd, 8'h04);
    bus_read(2'd0, rd); chk("rx_data", rd, rx_exp.pop_front());
    bus_read(2'd1, rd); chk("rx_empty", rd, 8'h05);
    bus_read(2'd0, rd); chk("rx_empty_rd", rd, 8'h00);

    // 5 RX overflow
    for (int i = 0; i < 9; i++) begin
      if (i < 8) rx_exp.push_back(8'(8'hA0 + 3 * i));
      rx_send(8'(8'hA0 + 3 * i));
    end
    bus_read(2'd1, rd); chk("rx_ovf_status", rd, 8'h16);
    while (rx_exp.size() != 0) begin
      bus_read(2'd0, rd); chk("rx_fifo", rd, rx_exp.pop_front());
    end
    bus_read(2'd0, rd); chk("rx_after_drain", rd, 8'h00);
    bus_write(2'd1, 8'h10);
    bus_read(2'd1, rd); chk("rx_ovf_clr", rd, 8'h05);

    // 6 interrupt
`ifdef UART_CTRL_IRQ_EN
    bus_write(2'd2, 8'h01);
    bus_read(2'd2, rd); chk("ctrl_rd", rd, 8'h01);
    chk("irq_idle", {7'b0, irq}, 8'h00);
    rx_send(8'h77);
    @(negedge clk);
    chk("irq_set", {7'b0, irq}, 8'h01);
    bus_read(2'd0, rd); chk("irq_data", rd, 8'h77);
    @(negedge clk);
    chk("irq_clr", {7'b0, irq}, 8'h00);
`else
    bus_write(2'd2, 8'h03);
    bus_read(2'd2, rd); chk("ctrl_rd", rd, 8'h00);
    rx_send(8'h77);
    @(negedge clk);
    chk("irq_off", {7'b0, irq}, 8'h00);
    bus_read(2'd0, rd); chk("irq_data", rd, 8'h77);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
